// File: rtl/jk_excite_pkg.sv
// ---------------------------------------------------------------------------
// jk_excite_pkg : FSM state type and JK excitation helper for jk_excite_counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jk_excite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {J, K} that moves one JK cell from q to nxt; never yields 2'b11.
  function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
    return {~q & nxt, q & ~nxt};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_excite_counter_if.sv
// ---------------------------------------------------------------------------
// jk_excite_counter_if : control, count and excitation bus of jk_excite_counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface jk_excite_counter_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             stop;
  logic             en;
  logic             up;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_max;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, en, up, oneshot, load, load_val, mod_max,
    input  q, j_out, k_out, busy, tc, done
  );

  modport slave (
    input  start, stop, en, up, oneshot, load, load_val, mod_max,
    output q, j_out, k_out, busy, tc, done
  );

endinterface

`default_nettype wire

// File: rtl/jk_bank.sv
// ---------------------------------------------------------------------------
// jk_bank : WIDTH independent JK storage cells, async active-low clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cell_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cell_q <= 1'b0;
      end else begin
        case ({j_i[i], k_i[i]})
          2'b00:   cell_q <= cell_q;
          2'b01:   cell_q <= 1'b0;
          2'b10:   cell_q <= 1'b1;
          default: cell_q <= ~cell_q;
        endcase
      end
    end

    assign q_o[i] = cell_q;
  end

endmodule

`default_nettype wire

// File: rtl/jk_excite_counter.sv
// ---------------------------------------------------------------------------
// jk_excite_counter : modulo up/down counter built from a JK bank driven by
//                     computed J/K excitation, with start/stop/one-shot FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_excite_counter
  import jk_excite_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  jk_excite_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic             at_top;
  logic             at_zero;
  logic             counting;
  logic             wrap;
  logic             busy;
  logic             tc_q;
  logic             tc_d;
  logic             done_q;
  logic             done_d;

  assign at_top  = (cnt_q >= bus.mod_max);
  assign at_zero = (cnt_q == '0);

  // Load outranks both stop and counting, so a load cycle is never a wrap.
  assign counting = (state_q == RUN) & bus.en & ~bus.stop & ~bus.load;
  assign wrap     = counting & (bus.up ? at_top : at_zero);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (counting) begin
      if (bus.up) begin
        cnt_d = at_top ? '0 : cnt_q + C_ONE;
      end else begin
        cnt_d = at_zero ? bus.mod_max : cnt_q - C_ONE;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    assign {j_drv[i], k_drv[i]} = jk_excite(cnt_q[i], cnt_d[i]);
  end

  jk_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .j_i   (j_drv),
    .k_i   (k_drv),
    .q_o   (cnt_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (wrap & bus.oneshot) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_q rises together with entry into DONE, so it spans exactly that cycle.
  always_comb begin
    busy   = (state_q == RUN);
    tc_d   = wrap;
    done_d = wrap & bus.oneshot;
  end

  assign bus.q     = cnt_q;
  assign bus.j_out = j_drv;
  assign bus.k_out = k_drv;
  assign bus.busy  = busy;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_excite_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_excite_counter : directed scenarios plus randomized run against a
//                        behavioural counter model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jk_excite_counter;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0] m_q;
  bit         m_run;
  bit         m_fin;
  bit         m_tc;
  bit         m_done;

  jk_excite_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_excite_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_nxt();
    int qi, mm;
    bit cnt;
    qi  = int'(m_q);
    mm  = int'(bus.mod_max);
    cnt = m_run && bus.en && !bus.stop && !bus.load;
    if (bus.load)  return bus.load_val;
    if (!cnt)      return m_q;
    if (bus.up)    return (qi >= mm) ? 8'd0 : 8'(qi + 1);
    return (qi == 0) ? 8'(mm) : 8'(qi - 1);
  endfunction

  task automatic model_step();
    logic [7:0] n;
    bit cnt, w;
    cnt = m_run && bus.en && !bus.stop && !bus.load;
    w   = cnt && (bus.up ? (m_q >= bus.mod_max) : (m_q == 8'd0));
    n   = model_nxt();
    m_tc   = w;
    m_done = w && bus.oneshot;
    if (m_fin)            m_fin = 1'b0;
    else if (!m_run)      m_run = bus.start;
    else if (bus.stop)    m_run = 1'b0;
    else if (w && bus.oneshot) begin
      m_run = 1'b0;
      m_fin = 1'b1;
    end
    m_q = n;
  endtask

  task automatic model_clear();
    m_q = 8'd0; m_run = 1'b0; m_fin = 1'b0; m_tc = 1'b0; m_done = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0; bus.up = 1'b1;
    bus.oneshot = 1'b0; bus.load = 1'b0; bus.load_val = 8'd0; bus.mod_max = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({bus.q, bus.busy, bus.tc, bus.done} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 000", {bus.q, bus.busy, bus.tc, bus.done});
    end
    #10;
    reset = 1'b1;
    bus.mod_max = 8'd9; bus.en = 1'b1; bus.up = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({bus.q, bus.busy} !== {8'd5, 1'b1}) begin
      failures++;
      $display("FAIL reset_prerun: got q=%h busy=%b expected q=05 busy=1", bus.q, bus.busy);
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({bus.q, bus.busy, bus.tc, bus.done} !== 11'd0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 000", {bus.q, bus.busy, bus.tc, bus.done});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.q, bus.busy} !== 9'd0) begin
      failures++;
      $display("FAIL reset_idle_after: got q=%h busy=%b expected q=00 busy=0", bus.q, bus.busy);
    end
  endtask

  task automatic test_up_wrap();
    int eq[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    idle_inputs();
    bus.mod_max = 8'd3; bus.en = 1'b1; bus.up = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        checks++;
        if ({bus.j_out, bus.k_out} !== {8'h02, 8'h01}) begin
          failures++;
          $display("FAIL up_excite_1to2: got j=%h k=%h expected j=02 k=01", bus.j_out, bus.k_out);
        end
      end
      tick();
      checks++;
      if ({bus.q, bus.tc} !== {8'(eq[i]), eq[i] == 0}) begin
        failures++;
        $display("FAIL up_wrap[%0d]: got q=%h tc=%b expected q=%h tc=%b",
                 i, bus.q, bus.tc, 8'(eq[i]), eq[i] == 0);
      end
    end
  endtask

  task automatic test_down();
    int eq[4] = '{0, 5, 4, 3};
    int et[4] = '{0, 1, 0, 0};
    idle_inputs();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.mod_max = 8'd5; bus.up = 1'b0; bus.load = 1'b1; bus.load_val = 8'd1;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.busy} !== {8'd1, 1'b1}) begin
      failures++;
      $display("FAIL down_loaded: got q=%h busy=%b expected q=01 busy=1", bus.q, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        checks++;
        if ({bus.j_out, bus.k_out} !== {8'h05, 8'h00}) begin
          failures++;
          $display("FAIL down_excite_0to5: got j=%h k=%h expected j=05 k=00", bus.j_out, bus.k_out);
        end
      end
      tick();
      checks++;
      if ({bus.q, bus.tc} !== {8'(eq[i]), et[i] == 1}) begin
        failures++;
        $display("FAIL down_seq[%0d]: got q=%h tc=%b expected q=%h tc=%b",
                 i, bus.q, bus.tc, 8'(eq[i]), et[i] == 1);
      end
    end
  endtask

  task automatic test_oneshot();
    int eq[5] = '{1, 2, 0, 0, 0};
    int ef[5] = '{0, 0, 1, 0, 0};
    int eb[5] = '{1, 1, 0, 0, 0};
    idle_inputs();
    do_reset();
    bus.mod_max = 8'd2; bus.up = 1'b1; bus.en = 1'b1; bus.oneshot = 1'b1; bus.start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 3);
      tick();
      checks++;
      if ({bus.q, bus.tc, bus.done, bus.busy} !== {8'(eq[i]), ef[i] == 1, ef[i] == 1, eb[i] == 1}) begin
        failures++;
        $display("FAIL oneshot[%0d]: got q=%h tc=%b done=%b busy=%b expected q=%h tc=%b done=%b busy=%b",
                 i, bus.q, bus.tc, bus.done, bus.busy, 8'(eq[i]), ef[i] == 1, ef[i] == 1, eb[i] == 1);
      end
    end
  endtask

  task automatic test_load_wrap();
    idle_inputs();
    do_reset();
    bus.mod_max = 8'd7; bus.up = 1'b1; bus.en = 1'b1;
    bus.load = 1'b1; bus.load_val = 8'd7;
    tick();
    bus.load = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.load = 1'b1; bus.load_val = 8'hA5;
    tick();
    bus.load = 1'b0;
    checks++;
    if ({bus.q, bus.tc, bus.busy} !== {8'hA5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL load_in_wrap: got q=%h tc=%b busy=%b expected q=a5 tc=0 busy=1", bus.q, bus.tc, bus.busy);
    end
    tick();
    checks++;
    if ({bus.q, bus.tc} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL load_above_max_wrap: got q=%h tc=%b expected q=00 tc=1", bus.q, bus.tc);
    end
    tick();
    checks++;
    if ({bus.q, bus.tc} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL after_wrap_count: got q=%h tc=%b expected q=01 tc=0", bus.q, bus.tc);
    end
  endtask

  task automatic test_stop_resume();
    repeat (3) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++;
    if ({bus.q, bus.busy} !== {8'd4, 1'b0}) begin
      failures++;
      $display("FAIL stop_hold: got q=%h busy=%b expected q=04 busy=0", bus.q, bus.busy);
    end
    tick();
    checks++;
    if ({bus.q, bus.busy} !== {8'd4, 1'b0}) begin
      failures++;
      $display("FAIL stop_idle_en: got q=%h busy=%b expected q=04 busy=0", bus.q, bus.busy);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if ({bus.q, bus.busy} !== {8'd5, 1'b1}) begin
      failures++;
      $display("FAIL resume: got q=%h busy=%b expected q=05 busy=1", bus.q, bus.busy);
    end
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++;
    if ({bus.q, bus.busy} !== {8'd5, 1'b1}) begin
      failures++;
      $display("FAIL start_stop_idle: got q=%h busy=%b expected q=05 busy=1", bus.q, bus.busy);
    end
    tick();
    checks++;
    if (bus.q !== 8'd6) begin
      failures++;
      $display("FAIL start_stop_count: got q=%h expected q=06", bus.q);
    end
  endtask

  task automatic test_mod_zero();
    idle_inputs();
    do_reset();
    bus.mod_max = 8'd0; bus.up = 1'b1; bus.en = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.up = (i < 2);
      tick();
      checks++;
      if ({bus.q, bus.tc} !== {8'd0, 1'b1}) begin
        failures++;
        $display("FAIL mod_zero[%0d]: got q=%h tc=%b expected q=00 tc=1", i, bus.q, bus.tc);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] nx;
    idle_inputs();
    do_reset();
    bus.mod_max = 8'd6;
    for (int n = 0; n < 600; n++) begin
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.stop     = ($urandom_range(0, 15) == 0);
      bus.load     = ($urandom_range(0, 15) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.up       = ($urandom_range(0, 1) == 1);
      bus.oneshot  = ($urandom_range(0, 3) == 0);
      bus.load_val = 8'($urandom);
      if ($urandom_range(0, 19) == 0)
        bus.mod_max = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      #1;
      nx = model_nxt();
      checks++;
      if ({bus.j_out, bus.k_out} !== {nx & ~m_q, m_q & ~nx}) begin
        failures++;
        $display("FAIL rand_excite[%0d]: got j=%h k=%h expected j=%h k=%h",
                 n, bus.j_out, bus.k_out, nx & ~m_q, m_q & ~nx);
      end
      tick();
      checks++;
      if ({bus.q, bus.tc, bus.done, bus.busy} !== {m_q, m_tc, m_done, m_run}) begin
        failures++;
        $display("FAIL rand_state[%0d]: got q=%h tc=%b done=%b busy=%b expected q=%h tc=%b done=%b busy=%b",
                 n, bus.q, bus.tc, bus.done, bus.busy, m_q, m_tc, m_done, m_run);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_up_wrap();
    test_down();
    test_oneshot();
    test_load_wrap();
    test_stop_resume();
    test_mod_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_excite_counter.md
Name: jk_excite_counter

Overview:
- Excitation side of the team's JK storage cell: computes per-bit J/K drive from a desired next state and applies it to a bank of JK cells.
- Together they form a programmable modulo up/down counter with synchronous load and a start/stop/one-shot control FSM.
- Used as the standard counter/timer primitive in the Sequential IP set. Exposes J/K buses so verification can check excitation directly.

Parameters:
- WIDTH, 8, counter/JK bank width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  pulse; IDLE -> RUN.
- stop  input  1  pulse; RUN -> IDLE.
- en  input  1  count enable while in RUN.
- up  input  1  1 = count up, 0 = count down.
- oneshot  input  1  1 = stop after first wrap; 0 = free-run.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded on load.
- mod_max  input  WIDTH  terminal value; count range 0..mod_max.
- q  output  WIDTH  current count (JK bank state).
- j_out  output  WIDTH  combinational J drive to the bank.
- k_out  output  WIDTH  combinational K drive to the bank.
- busy  output  1  1 while FSM in RUN.
- tc  output  1  registered one-cycle pulse, asserted the cycle after a wrap.
- done  output  1  registered one-cycle pulse on one-shot completion.

Behaviour:
- Reset (reset=0, async): q=0, tc=0, done=0, busy=0, FSM=IDLE. Reset mid-count aborts with no pulses.
- Next-state computation:
  - nxt = load_val if load.
  - Otherwise, count if FSM=RUN & en & ~stop:
    - up: nxt = 0 if q>=mod_max, else q+1.
    - down: nxt = mod_max if q==0, else q-1.
  - Otherwise nxt = q.
- Excitation, per bit i: j_out[i] = ~q[i] & nxt[i]; k_out[i] = q[i] & ~nxt[i]. J=K=1 never occurs; hold gives J=K=0.
- JK bank updates q on the rising edge with standard JK semantics: 00 hold, 01 clear, 10 set, 11 toggle. Result: q <= nxt, latency 1 cycle.
- Wrap event is a counting cycle with (up & q>=mod_max) or (~up & q==0). tc=1 in the following cycle only.
- Priority: load > stop > count.
  - load in a would-be wrap cycle: load wins, no tc.
  - load does not change FSM state.
- FSM:
  - IDLE: start -> RUN. busy=0, no counting.
  - RUN: busy=1.
    - stop -> IDLE, no count that cycle.
    - Else wrap & oneshot -> DONE.
    - start ignored.
  - DONE: done=1 for this one cycle, busy=0, no counting; unconditional -> IDLE. start in DONE ignored.
- Boundary cases:
  - mod_max=0: q stays 0 and tc pulses every counting cycle.
  - load_val>mod_max: up wraps to 0 on next count; down decrements normally.
  - mod_max changed mid-run: new value takes effect the same cycle.
  - start & stop together in IDLE: start wins; stop is evaluated only in RUN.

Decomposition:
- Package jk_excite_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
  - Function jk_excite(q, nxt) returning the {J,K} pair per bit.
- Sub-module jk_bank: WIDTH JK cells with shared clk and async active-low reset, output q. Instantiated once.
- Remaining logic (next-state, excitation, FSM, tc/done registers) lives in jk_excite_counter.

Test Plan:
1. Reset low mid-run with q=5 -> q=0, busy=0, tc=0, done=0 immediately (before any clk edge); FSM=IDLE after release.
2. WIDTH=8, mod_max=3, up=1, en=1, oneshot=0, start pulse -> q goes 0,1,2,3,0,1…; tc high exactly in cycles where q newly = 0; check j_out/k_out for 1->2: j_out=8'h02, k_out=8'h01.
3. Down count, mod_max=5, load_val=1 then start -> q goes 1,0,5,4…; tc one cycle after the 0->5 transition; j_out=8'h05, k_out=0 on that step.
4. oneshot=1, mod_max=2, up -> q goes 0,1,2,0; done pulses one cycle, then busy=0 and q holds 0 despite en=1.
5. load=1 with load_val=8'hA5 in the wrap cycle (q=mod_max=7, up) -> q=8'hA5, no tc; next up count wraps to 0 since A5>7.
6. stop in RUN with en=1 at q=4 -> q stays 4, busy drops next cycle; later start resumes from 4.
